// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle controller.
// The PERF_CNT_EN macro enables the cycle and retire counters in the top.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_ILL
  } cls_e;

  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ = 11'b11111111000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/legv8_op_classify.sv
// Combinational opcode-to-class decoder for the LEGv8 controller.
// Feeds the DECODE-stage class register in the top.
module legv8_op_classify
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output cls_e        cls
);

  always_comb begin
    cls = CLS_ILL;
    unique case (1'b1)
      (opcode == OP_STUR):              cls = CLS_STUR;
      (opcode == OP_LDUR):              cls = CLS_LDUR;
      ((opcode & MASK_CBZ) == OP_CBZ):  cls = CLS_CBZ;
      is_rtype(opcode):                 cls = CLS_R;
      default:                          cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 datapath.
// Define PERF_CNT_EN to build the cyc_cnt/ret_cnt performance counters.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             br,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  cls_e   cls_in;
  logic   en_q, en_d;

  legv8_op_classify u_cls (
    .opcode (opcode),
    .cls    (cls_in)
  );

  // en_q holds the outputs quiet until the first edge after reset release
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    en_d    = 1'b1;
    if (en_q) begin
      unique case (state_q)
        S_FETCH:
          if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          cls_d   = cls_in;
          state_d = (cls_in == CLS_ILL) ? S_TRAP : S_EXEC;
        end
        S_EXEC:
          case (cls_q)
            CLS_R:    state_d = S_WB;
            CLS_LDUR: state_d = S_MEM;
            CLS_STUR: state_d = S_MEM;
            default:  state_d = S_FETCH;
          endcase
        S_MEM:
          if (mem_ready)
            state_d = (cls_q == CLS_LDUR) ? S_WB : S_FETCH;
        S_WB:     state_d = S_FETCH;
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_ILL;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    br         = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (en_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        // class is not registered yet, so DECODE looks at the live opcode
        S_DECODE:
          reg2loc = (cls_in == CLS_STUR);
        S_EXEC:
          case (cls_q)
            CLS_R: alu_op = ALUOP_RTYPE;
            CLS_LDUR: alu_src = 1'b1;
            CLS_STUR: begin
              alu_src = 1'b1;
              reg2loc = 1'b1;
            end
            CLS_CBZ: begin
              reg2loc  = 1'b1;
              alu_op   = ALUOP_PASS;
              pc_write = alu_zero;
              br       = alu_zero;
            end
            default: ;
          endcase
        S_MEM: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_read  = (cls_q == CLS_LDUR);
          mem_write = (cls_q == CLS_STUR);
          reg2loc   = (cls_q == CLS_STUR);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == CLS_LDUR);
        end
        S_TRAP:
          illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  // retirement is counted once the class is known, so traps never count
  always_comb begin
    cyc_d = cyc_q + CNT_W'(1);
    ret_d = ret_q;
    if (en_q && state_q == S_DECODE && cls_in != CLS_ILL)
      ret_d = ret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Randomized bench for legv8_multicycle_ctrl against a per-instruction
// cycle-sequence model built from the instruction-class rules.
module tb_legv8_multicycle_ctrl;

  localparam int CNT_W = 32;
  localparam int C_R = 0, C_L = 1, C_S = 2, C_B = 3, C_I = 4;

  logic clk, rst_n;
  logic [10:0] opcode;
  logic alu_zero, mem_ready;
  logic mem_req, iord, mem_read, mem_write, ir_write, pc_write, br;
  logic reg2loc, alu_src, mem_to_reg, reg_write, illegal;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;

  legv8_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .br(br), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_ret = 0;
  int n_edges = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) n_edges <= 0;
    else n_edges <= n_edges + 1;

  wire [13:0] obs = {mem_req, iord, mem_read, mem_write, ir_write,
                     pc_write, br, reg2loc, alu_src, alu_op,
                     mem_to_reg, reg_write, illegal};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [13:0] ov(
      bit mreq, bit io, bit rd, bit wr, bit irw, bit pcw, bit b,
      bit r2l, bit src, logic [1:0] aop, bit m2r, bit rw, bit ill);
    return {mreq, io, rd, wr, irw, pcw, b, r2l, src, aop, m2r, rw, ill};
  endfunction

  typedef struct {
    logic [13:0] v;
    bit          rdy_fix;
    bit          rdy;
    bit          dec;
    bit          az_fix;
    string       tag;
  } cyc_t;

  function automatic bit legal(logic [10:0] op);
    logic [10:0] hi;
    hi = op & 11'b11111111000;
    return op == 11'b11111000000 || op == 11'b11111000010 ||
           hi == 11'b10110100000 || op == 11'b10001011000 ||
           op == 11'b11001011000 || op == 11'b10001010000 ||
           op == 11'b10101010000;
  endfunction

  function automatic logic [10:0] gen_op(int cls);
    logic [10:0] op;
    logic [10:0] rt [4];
    rt[0] = 11'b10001011000; rt[1] = 11'b11001011000;
    rt[2] = 11'b10001010000; rt[3] = 11'b10101010000;
    case (cls)
      C_R: op = rt[$urandom_range(0, 3)];
      C_L: op = 11'b11111000010;
      C_S: op = 11'b11111000000;
      C_B: op = {8'b10110100, 3'($urandom)};
      default: begin
        op = 11'($urandom);
        while (legal(op)) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  function automatic cyc_t mk(logic [13:0] v, bit rf, bit r, string t);
    cyc_t c;
    c.v = v; c.rdy_fix = rf; c.rdy = r;
    c.dec = 0; c.az_fix = 0; c.tag = t;
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", {18'd0, obs}, 32'd0);
    chk("rst_cyc", cyc_cnt, 32'd0);
    chk("rst_ret", ret_cnt, 32'd0);
    n_ret = 0;
    rst_n = 1'b1;
    #1;
    chk("rel_outs", {18'd0, obs}, 32'd0);
    @(posedge clk);
  endtask

  task automatic run_inst(input int cls, input logic [10:0] op,
                          input int fw, input int mw, input bit z);
    cyc_t q[$];
    cyc_t c;
    logic [31:0] exp_cyc, exp_ret;
    for (int i = 0; i < fw; i++)
      q.push_back(mk(ov(1,0,1,0,0,0,0,0,0,2'b00,0,0,0), 1, 0, "fetch_w"));
    q.push_back(mk(ov(1,0,1,0,1,1,0,0,0,2'b00,0,0,0), 1, 1, "fetch"));
    c = mk(ov(0,0,0,0,0,0,0,cls == C_S,0,2'b00,0,0,0), 0, 0, "dec");
    c.dec = 1;
    q.push_back(c);
    case (cls)
      C_R: begin
        q.push_back(mk(ov(0,0,0,0,0,0,0,0,0,2'b10,0,0,0), 0, 0, "exec_r"));
        q.push_back(mk(ov(0,0,0,0,0,0,0,0,0,2'b00,0,1,0), 0, 0, "wb_r"));
      end
      C_L, C_S: begin
        q.push_back(mk(ov(0,0,0,0,0,0,0,cls == C_S,1,2'b00,0,0,0),
                       0, 0, "exec_ls"));
        for (int i = 0; i <= mw; i++)
          q.push_back(mk(ov(1,1,cls == C_L,cls == C_S,0,0,0,cls == C_S,
                            0,2'b00,0,0,0), 1, i == mw, "mem"));
        if (cls == C_L)
          q.push_back(mk(ov(0,0,0,0,0,0,0,0,0,2'b00,1,1,0), 0, 0, "wb_l"));
      end
      C_B: begin
        c = mk(ov(0,0,0,0,0,z,z,1,0,2'b01,0,0,0), 0, 0, "exec_cbz");
        c.az_fix = 1;
        q.push_back(c);
      end
      default:
        for (int i = 0; i < 4; i++)
          q.push_back(mk(ov(0,0,0,0,0,0,0,0,0,2'b00,0,0,1), 0, 0, "trap"));
    endcase
    foreach (q[i]) begin
      @(negedge clk);
      opcode    = q[i].dec ? op : 11'($urandom);
      mem_ready = q[i].rdy_fix ? q[i].rdy : 1'($urandom);
      alu_zero  = q[i].az_fix ? z : 1'($urandom);
      #1;
      chk(q[i].tag, {18'd0, obs}, {18'd0, q[i].v});
    end
    if (cls != C_I) n_ret++;
`ifdef PERF_CNT_EN
    exp_cyc = n_edges;
    exp_ret = n_ret;
`else
    exp_cyc = 0;
    exp_ret = 0;
`endif
    chk("cyc_cnt", cyc_cnt, exp_cyc);
    chk("ret_cnt", ret_cnt, exp_ret);
  endtask

  initial begin
    int cls;
    rst_n = 1'b1;
    opcode = '0;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    #2;
    do_reset();

    run_inst(C_R, 11'b10001011000, 0, 0, 0);
    run_inst(C_L, 11'b11111000010, 2, 3, 0);
    run_inst(C_S, 11'b11111000000, 0, 0, 0);
    run_inst(C_R, 11'b10001011000, 0, 0, 0);
    run_inst(C_B, 11'b10110100101, 0, 0, 1);
    run_inst(C_B, 11'b10110100101, 0, 0, 0);
    run_inst(C_I, 11'b00000000000, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 3; i++)
      run_inst(C_R, 11'b10001011000, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 15);
      if (cls > C_I) cls = $urandom_range(C_R, C_B);
      run_inst(cls, gen_op(cls), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom));
      if (cls == C_I) do_reset();
    end

    // asynchronous abort in the middle of a STUR data access
    @(negedge clk); opcode = 11'($urandom); mem_ready = 1'b1; #1;
    chk("ab_fetch", {18'd0, obs}, {18'd0, ov(1,0,1,0,1,1,0,0,0,2'b00,0,0,0)});
    @(negedge clk); opcode = 11'b11111000000; mem_ready = 1'b0; #1;
    chk("ab_dec", {18'd0, obs}, {18'd0, ov(0,0,0,0,0,0,0,1,0,2'b00,0,0,0)});
    @(negedge clk); opcode = 11'($urandom); #1;
    chk("ab_exec", {18'd0, obs}, {18'd0, ov(0,0,0,0,0,0,0,1,1,2'b00,0,0,0)});
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("ab_mem_wr", {31'd0, mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ab_wr_drop", {31'd0, mem_write}, 32'd0);
    chk("ab_outs", {18'd0, obs}, 32'd0);
    do_reset();
    run_inst(C_S, 11'b11111000000, 1, 2, 0);
    run_inst(C_R, 11'b11001011000, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
